// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - slot geometry and active-high gfedcba hex glyphs
package seven_seg_scanner_pkg;

  localparam int         SLOT_SUBTICKS = 16;
  localparam logic [3:0] LAST_SUBTICK  = 4'(SLOT_SUBTICKS - 1);
  localparam logic [3:0] DEAD_SUBTICK  = 4'd15;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seven_seg_scanner_hex_seg_decoder.sv
// rtl/seven_seg_scanner_hex_seg_decoder.sv - nibble to active-high 7-segment pattern
module hex_seg_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = GLYPH_0;
    case (nibble)
      4'h0: pattern = GLYPH_0;
      4'h1: pattern = GLYPH_1;
      4'h2: pattern = GLYPH_2;
      4'h3: pattern = GLYPH_3;
      4'h4: pattern = GLYPH_4;
      4'h5: pattern = GLYPH_5;
      4'h6: pattern = GLYPH_6;
      4'h7: pattern = GLYPH_7;
      4'h8: pattern = GLYPH_8;
      4'h9: pattern = GLYPH_9;
      4'hA: pattern = GLYPH_A;
      4'hB: pattern = GLYPH_B;
      4'hC: pattern = GLYPH_C;
      4'hD: pattern = GLYPH_D;
      4'hE: pattern = GLYPH_E;
      default: pattern = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed N-digit 7-segment driver with PWM, blink and dead slot
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 6250,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int SCAN_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SCAN_W-1:0]       scan_idx,
  output logic                    frame_start
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW}};

  logic                run;
  logic [TICK_W-1:0]   tick_cnt;
  logic [3:0]          sub_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;

  logic [3:0]          nib_l;
  logic                dp_l;
  logic                blank_l;
  logic                blink_en_l;

  logic                slot_start;
  logic                tick_wrap;
  logic                sub_wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_blink_en;
  logic [3:0]          eff_nib;
  logic                eff_dp;
  logic                eff_blank;
  logic                eff_blink_en;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [6:0]          glyph;
  logic                lit;

  hex_seg_decoder u_decoder (
    .nibble  (eff_nib),
    .pattern (glyph)
  );

  // On the first cycle of a slot the latch is still loading, so use the live inputs
  // for that cycle; this keeps the output at exactly one cycle behind the counters.
  always_comb begin
    slot_start   = (tick_cnt == '0) && (sub_cnt == 4'd0);
    tick_wrap    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    sub_wrap     = (sub_cnt == LAST_SUBTICK);
    cur_nib      = 4'd0;
    cur_dp       = 1'b0;
    cur_blank    = 1'b1;
    cur_blink_en = 1'b0;
    an_hot       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_cnt == SCAN_W'(i)) begin
        cur_nib      = digits[4*i +: 4];
        cur_dp       = dp_in[i];
        cur_blank    = blank[i];
        cur_blink_en = blink_en[i];
        an_hot[i]    = 1'b1;
      end
    end
    eff_nib      = slot_start ? cur_nib      : nib_l;
    eff_dp       = slot_start ? cur_dp       : dp_l;
    eff_blank    = slot_start ? cur_blank    : blank_l;
    eff_blink_en = slot_start ? cur_blink_en : blink_en_l;
    lit = run && (sub_cnt < brightness) && (sub_cnt != DEAD_SUBTICK) &&
          !eff_blank && !(eff_blink_en && blink_phase);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      tick_cnt    <= '0;
      sub_cnt     <= 4'd0;
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      nib_l       <= 4'd0;
      dp_l        <= 1'b0;
      blank_l     <= 1'b1;
      blink_en_l  <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      scan_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (slot_start) begin
          nib_l      <= cur_nib;
          dp_l       <= cur_dp;
          blank_l    <= cur_blank;
          blink_en_l <= cur_blink_en;
        end
        if (tick_wrap) begin
          tick_cnt <= '0;
          sub_cnt  <= sub_cnt + 4'd1;
          if (sub_wrap) begin
            scan_cnt <= (scan_cnt == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_cnt + SCAN_W'(1);
          end
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
      an          <= lit ? (an_hot ^ AN_OFF) : AN_OFF;
      seg         <= lit ? ({eff_dp, glyph} ^ SEG_OFF) : SEG_OFF;
      scan_idx    <= scan_cnt;
      frame_start <= run && slot_start && (scan_cnt == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner (4 digits, TICK_DIV=2, BLINK_DIV=64)
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  blink_en;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_start;

  int passed = 0;
  int total  = 0;
  int c      = 0;
  logic [3:0] ann  [128];
  logic [7:0] segs [128];

  seven_seg_scanner #(
    .NUM_DIGITS (4),
    .TICK_DIV   (2),
    .BLINK_DIV  (64),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank       (blank),
    .blink_en    (blink_en),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .scan_idx    (scan_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Frame of 128 output cycles: 4 slots x 16 sub-ticks x 2 clocks; blink phase 1 in the second half.
  function automatic logic [14:0] expv(input int cc);
    int p, d, sub;
    logic ph, lit;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    p   = cc % 128;
    d   = p / 32;
    sub = (p % 32) / 2;
    ph  = (p >= 64);
    lit = (sub < int'(brightness)) && (sub != 15) && !blank[d] && !(blink_en[d] && ph);
    an_e  = lit ? ~(4'b0001 << d) : 4'hF;
    seg_e = lit ? ~{dp_in[d], glyph(digits[4*d +: 4])} : 8'hFF;
    return {(p == 0), 2'(d), an_e, seg_e};
  endfunction

  function automatic int count_an(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 128; i++) if (ann[i] === v) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    c++;
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 128; i++) begin
      step();
      ann[i]  = an;
      segs[i] = seg;
      chk($sformatf("%s_c%0d", tag, i), {17'd0, frame_start, scan_idx, an, seg}, {17'd0, expv(c)});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    digits     = 16'h1234;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    blink_en   = 4'b0000;
    brightness = 4'd15;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_scan", scan_idx, 2'd0);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c = -1;
    chk("rel_edge1_an", an, 4'b1111);

    run_frame("t2");
    chk("t2_first_an", ann[0], 4'b1110);
    chk("t2_d0_seg", segs[0], 8'h99);
    chk("t2_d3_seg", segs[96], 8'hF9);
    chk("t2_dead_an", ann[30], 4'b1111);
    chk("t2_d1_an", ann[32], 4'b1101);
    chk("t2_d2_an", ann[64], 4'b1011);
    chk("t2_d3_an", ann[96], 4'b0111);
    chk("t2_d0_lit", count_an(4'b1110), 30);
    chk("t2_d3_lit", count_an(4'b0111), 30);

    brightness = 4'd0;
    run_frame("t3a");
    chk("t3_off_dark", count_an(4'b1111), 128);
    brightness = 4'd4;
    run_frame("t3b");
    chk("t3_b4_d0_lit", count_an(4'b1110), 8);
    chk("t3_b4_d2_lit", count_an(4'b1011), 8);

    brightness = 4'd15;
    blank      = 4'b0100;
    dp_in      = 4'b0001;
    run_frame("t4");
    chk("t4_d0_dp_seg", segs[0], 8'h19);
    chk("t4_d2_blank", count_an(4'b1011), 0);

    blank    = 4'b0000;
    dp_in    = 4'b0000;
    blink_en = 4'b1001;
    run_frame("t5");
    chk("t5_d0_lit", count_an(4'b1110), 30);
    chk("t5_d3_blink", count_an(4'b0111), 0);
    chk("t5_d2_lit", count_an(4'b1011), 30);

    blink_en = 4'b0000;
    for (int i = 0; i < 128; i++) begin
      step();
      ann[i]  = an;
      segs[i] = seg;
      if (i == 10) digits = 16'h5678;
    end
    chk("t6_hold_c11", segs[11], 8'h99);
    chk("t6_hold_c29", segs[29], 8'h99);
    chk("t6_next_slot", segs[32], 8'hF8);
    run_frame("t6");
    chk("t6_new_d0", segs[0], 8'h80);

    repeat (40) step();
    chk("t6_pre_rst_scan", scan_idx, 2'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_an", an, 4'b1111);
    chk("t6_rst_seg", seg, 8'hFF);
    chk("t6_rst_scan", scan_idx, 2'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
